// File: rtl/ren_conv_pkg.sv
// Shared types and constants for the Renzym convolver Wishbone front-end.
package ren_conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RWAIT = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  localparam int unsigned STAT_DONE    = 0;
  localparam int unsigned STAT_BUS_ERR = 1;

  // Local registers sit at the top of window 0: word = 2^AWIDTH - offset.
  localparam int unsigned LOC_STATUS_OFS = 2;
  localparam int unsigned LOC_IRQ_EN_OFS = 1;

  function automatic int unsigned loc_word(input int unsigned awidth, input int unsigned ofs);
    return (32'd1 << awidth) - ofs;
  endfunction

endpackage

// File: rtl/ren_conv_wb_slave_irq_ctrl.sv
// Done/bus-error interrupt: STATUS (write-1-to-clear), IRQ_EN and the irq output.
module ren_conv_irq_ctrl
  import ren_conv_pkg::*;
(
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic       done_i,
  input  logic       bus_err_i,
  input  logic       w1c_we_i,
  input  logic       en_we_i,
  input  logic [1:0] wdat_i,
  output logic [1:0] status_o,
  output logic [1:0] irq_en_o,
  output logic       irq_o
);

  logic [1:0] status_q, status_d;
  logic [1:0] irq_en_q, irq_en_d;

  always_comb begin
    status_d = status_q;
    irq_en_d = irq_en_q;
    if (w1c_we_i) status_d = status_q & ~wdat_i;
    // Sets are applied after the clear so a coincident event is never lost.
    if (done_i)    status_d[STAT_DONE]    = 1'b1;
    if (bus_err_i) status_d[STAT_BUS_ERR] = 1'b1;
    if (en_we_i)   irq_en_d = wdat_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      status_q <= '0;
      irq_en_q <= '0;
    end else begin
      status_q <= status_d;
      irq_en_q <= irq_en_d;
    end
  end

  assign status_o = status_q;
  assign irq_en_o = irq_en_q;
  assign irq_o    = |(status_q & irq_en_q);

endmodule

// File: rtl/ren_conv_wb_slave.sv
// Wishbone slave bridge: NWIN-window decode, read wait states, write locking
// and local interrupt registers for the Renzym convolver.
//
// state    | meaning
// ST_IDLE  | waiting for a request; writes, errors and local accesses decided here
// ST_RWAIT | read issued, counting down RAM latency
// ST_ACK   | ack or err pulse on the bus; requests ignored
module ren_conv_wb_slave
  import ren_conv_pkg::*;
#(
  parameter int unsigned     DWIDTH      = 32,
  parameter int unsigned     AWIDTH      = 6,
  parameter int unsigned     NWIN        = 4,
  parameter int unsigned     WIN_SEL_LSB = 8,
  parameter int unsigned     RD_LAT      = 1,
  parameter logic [NWIN-1:0] LOCK_MASK   = 4'b0110
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [DWIDTH/8-1:0]    wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [DWIDTH-1:0]      wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic                   wbs_err_o,
  output logic [DWIDTH-1:0]      wbs_dat_o,
  output logic [NWIN-1:0]        win_we_o,
  output logic [NWIN-1:0]        win_re_o,
  output logic [DWIDTH/8-1:0]    win_be_o,
  output logic [AWIDTH-1:0]      win_adr_o,
  output logic [DWIDTH-1:0]      win_wdat_o,
  input  logic [NWIN*DWIDTH-1:0] win_rdat_i,
  input  logic                   eng_busy_i,
  input  logic                   eng_done_i,
  output logic                   irq_o
);

  localparam int unsigned WSEL_W = $clog2(NWIN);
  localparam int unsigned CNT_W  = 3;
  localparam logic [AWIDTH-1:0] STATUS_WORD = AWIDTH'(loc_word(AWIDTH, LOC_STATUS_OFS));
  localparam logic [AWIDTH-1:0] IRQ_EN_WORD = AWIDTH'(loc_word(AWIDTH, LOC_IRQ_EN_OFS));

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d, err_q, err_d;
  logic [DWIDTH-1:0]  dat_q, dat_d;

  logic               valid, oob, locked, illegal;
  logic               is_status, is_irq_en, is_local;
  logic [WSEL_W-1:0]  win_idx;
  logic [AWIDTH-1:0]  word;
  logic [NWIN-1:0]    win_onehot;
  logic [DWIDTH-1:0]  rdat_sel, loc_rdat;
  logic               bus_err_set, w1c_we, en_we;
  logic [1:0]         status, irq_en;
  logic               unused_adr;

  assign valid      = wbs_cyc_i & wbs_stb_i;
  assign win_idx    = wbs_adr_i[WIN_SEL_LSB +: WSEL_W];
  assign word       = wbs_adr_i[AWIDTH+1:2];
  assign oob        = 32'(win_idx) >= NWIN;
  assign win_onehot = NWIN'(1) << win_idx;
  assign is_status  = (win_idx == '0) && (word == STATUS_WORD);
  assign is_irq_en  = (win_idx == '0) && (word == IRQ_EN_WORD);
  assign is_local   = is_status | is_irq_en;
  assign illegal    = oob | (wbs_we_i & locked & eng_busy_i);
  assign unused_adr = ^wbs_adr_i;

  always_comb begin
    locked   = 1'b0;
    rdat_sel = '0;
    for (int unsigned k = 0; k < NWIN; k++) begin
      if (32'(win_idx) == k) begin
        locked   = LOCK_MASK[k];
        rdat_sel = win_rdat_i[k*DWIDTH +: DWIDTH];
      end
    end
    loc_rdat      = '0;
    loc_rdat[1:0] = is_status ? status : irq_en;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    dat_d       = dat_q;
    win_we_o    = '0;
    win_re_o    = '0;
    bus_err_set = 1'b0;
    w1c_we      = 1'b0;
    en_we       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          state_d = ST_ACK;
          if (illegal) begin
            err_d       = 1'b1;
            bus_err_set = 1'b1;
          end else if (is_local) begin
            ack_d = 1'b1;
            if (wbs_we_i) begin
              w1c_we = is_status & wbs_sel_i[0];
              en_we  = is_irq_en & wbs_sel_i[0];
            end else begin
              dat_d = loc_rdat;
            end
          end else if (wbs_we_i) begin
            ack_d = 1'b1;
            if (|wbs_sel_i) win_we_o = win_onehot;
          end else begin
            win_re_o = win_onehot;
            cnt_d    = CNT_W'(RD_LAT);
            if (RD_LAT == 0) begin
              ack_d = 1'b1;
              dat_d = rdat_sel;
            end else begin
              state_d = ST_RWAIT;
            end
          end
        end
      end
      ST_RWAIT: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          dat_d   = rdat_sel;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_err_o  = err_q;
  assign wbs_dat_o  = dat_q;
  assign win_be_o   = wbs_sel_i;
  assign win_adr_o  = word;
  assign win_wdat_o = wbs_dat_i;

  ren_conv_irq_ctrl u_irq (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .done_i    (eng_done_i),
    .bus_err_i (bus_err_set),
    .w1c_we_i  (w1c_we),
    .en_we_i   (en_we),
    .wdat_i    (wbs_dat_i[1:0]),
    .status_o  (status),
    .irq_en_o  (irq_en),
    .irq_o     (irq_o)
  );

endmodule

// File: doc/ren_conv_wb_slave.md
# ren_conv_wb_slave

Parametrised Wishbone slave front-end for the Renzym convolver; it generalises the fixed four-window decode of the convolver top into a configurable bus bridge. It decodes NWIN address windows, honours byte selects, and inserts wait states for synchronous RAMs of configurable read latency. It locks RAM windows against writes while the engine runs and returns a bus error for illegal accesses. It also owns a done/error interrupt with local status and enable registers.

## Interface
- DWIDTH, 32, bus data width; must be a multiple of 8.
- AWIDTH, 6, word-address width forwarded to every window.
- NWIN, 4, number of windows; window 0 is the config-register window; range 2..8.
- WIN_SEL_LSB, 8, lowest address bit of the window index; requires AWIDTH+2 <= WIN_SEL_LSB.
- RD_LAT, 1, cycles from win_re_o to valid win_rdat_i; range 0..7.
- LOCK_MASK, 4'b0110, one bit per window; a set bit blocks writes while eng_busy_i=1.
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone classic strobe, cycle and write enable.
- wbs_sel_i  in  DWIDTH/8  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  DWIDTH  write data.
- wbs_ack_o, wbs_err_o  out  1  registered termination signals; one-cycle pulses.
- wbs_dat_o  out  DWIDTH  registered read data.
- win_we_o, win_re_o  out  NWIN  one-hot write and read strobes.
- win_be_o  out  DWIDTH/8  byte enables; equals wbs_sel_i.
- win_adr_o  out  AWIDTH  wbs_adr_i[AWIDTH+1:2].
- win_wdat_o  out  DWIDTH  equals wbs_dat_i.
- win_rdat_i  in  NWIN*DWIDTH  concatenated read data; window k occupies bits [k*DWIDTH +: DWIDTH].
- eng_busy_i  in  1  convolver running.
- eng_done_i  in  1  one-cycle done pulse from the convolver.
- irq_o  out  1  interrupt, equal to |(status & enable).

## Operation
- Request: valid = wbs_cyc_i & wbs_stb_i. The window index is wbs_adr_i[WIN_SEL_LSB +: clog2(NWIN)].
- Local registers: window 0 at word addresses 2^AWIDTH-2 and 2^AWIDTH-1.
  - Word 2^AWIDTH-2 is STATUS: bit0 done, bit1 bus_err; it is write-1-to-clear.
  - Word 2^AWIDTH-1 is IRQ_EN: bits[1:0], read/write.
  - Accesses to these two words are served locally and never forwarded.
- Error conditions, each terminated by wbs_err_o with no strobe issued:
  - the window index is >= NWIN;
  - a write targets a window whose LOCK_MASK bit is set while eng_busy_i=1.
  - Reads of locked windows are always legal.
- An error sets STATUS.bus_err.
- A write with wbs_sel_i=0 is acked and no win_we_o is asserted.
- FSM states: IDLE, RWAIT, ACK.
  - IDLE, valid, legal write: win_we_o[win] is asserted combinationally this cycle -> ACK.
  - IDLE, valid, legal read: win_re_o[win] is asserted for one cycle and the latency counter is loaded with RD_LAT.
    - If RD_LAT=0, win_rdat_i is captured into wbs_dat_o this cycle -> ACK.
    - Otherwise -> RWAIT.
  - IDLE, valid, illegal access -> ACK with the error flag set.
  - RWAIT: the counter decrements. When it reaches 1, win_rdat_i[win] is captured and the state -> ACK.
  - RWAIT with wbs_cyc_i=0: the transfer is aborted and the state -> IDLE. No ack is given and wbs_dat_o is unchanged.
  - ACK: wbs_ack_o or wbs_err_o is high for exactly one cycle -> IDLE. New requests are not sampled in ACK.
- Interrupt status:
  - STATUS.done is set on the cycle after eng_done_i=1.
  - If a set and a W1C clear of the same bit happen in one cycle, the set wins.
  - W1C and IRQ_EN writes use byte 0 only.

## Timing
- Reset values: FSM in IDLE; wbs_ack_o, wbs_err_o, wbs_dat_o, STATUS, IRQ_EN and irq_o all 0; no strobes.
- Writes: request in cycle N -> strobe in cycle N, ack or err in cycle N+1.
- Reads: request in cycle N -> ack in cycle N+1+RD_LAT. Local-register reads ack in N+1.
- The master holds address and data stable until termination. Back-to-back requests are accepted at the earliest in the cycle after ACK.
- Reset asserted mid-transfer clears all state immediately; no termination is issued for the aborted transfer.

## Structure
- The shared package ren_conv_pkg holds:
  - the state enum;
  - the STATUS bit indices (DONE=0, BUS_ERR=1);
  - the local-register offsets, expressed relative to 2^AWIDTH.
- The natural sub-module is ren_conv_irq_ctrl: STATUS, IRQ_EN, W1C logic and irq_o. The FSM and decode stay in the top.

## Test plan
- Write window 1, word 5, sel 4'hF, data 32'h00A5A5A5 -> win_we_o=4'b0010 and win_adr_o=5 in cycle N; wbs_ack_o=1 in N+1; wbs_err_o stays 0.
- RD_LAT=2, read window 3 word 9 with win_rdat_i[3]=32'hDEADBEEF -> win_re_o=4'b1000 in cycle N; ack in N+3 with wbs_dat_o=32'hDEADBEEF.
- eng_busy_i=1, write window 2 -> no win_we_o; wbs_err_o in N+1; STATUS reads 2'b10; with IRQ_EN=2'b10, irq_o=1.
- NWIN=3, access with window index 3 -> err. eng_done_i pulse with IRQ_EN=1 -> irq_o high the next cycle. W1C of 1 coinciding with a new done pulse -> STATUS.done stays 1.
- RD_LAT=3, drop wbs_cyc_i in RWAIT -> no ack and the FSM is back in IDLE; the following read of window 0 word 0 acks normally.
- Assert wb_rst_ni=0 mid-read -> wbs_ack_o, wbs_err_o and irq_o go to 0 and STATUS clears; after release the first request completes with standard latency.
